mod_det_seq: RTL and testbench

- Sequential signed determinant engine for 2x2 or 3x3 matrices, selected per operation by `modo`.
- Sits in the coprocessor datapath beside the combinational determinant and multiply units.
- Uses one shared signed multiplier, iterated under an FSM, with a start/busy/done handshake.
- Returns the full-precision result plus a DATA_W-bit wrapped result and an overflow flag.

---
 rtl/mod_det_seq.sv | 195 +++++++++++++++++++
 tb/tb_mod_det_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_det_seq.sv
// Sequential signed 2x2/3x3 determinant engine: one shared DATA_W x (2*DATA_W+1)
// multiplier iterated by a small FSM, start/busy/done handshake.
module mod_det_seq #(
    parameter int DATA_W = 8,
    parameter int FULL_W = 3*DATA_W+2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  modo,
    input  logic [9*DATA_W-1:0]   matriz,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     resultado,
    output logic [FULL_W-1:0]     resultado_full,
    output logic                  overflow,
    output logic [1:0]            o_dbg_state
);

    localparam int MIN_W  = 2*DATA_W+1;
    localparam int PROD_W = 3*DATA_W+1;

    typedef enum logic [1:0] {S_IDLE, S_MINOR, S_COF, S_FIM} state_t;

    state_t                    r_state, w_state_nxt;
    logic [2:0]                r_step, w_step_nxt;
    logic                      w_accept, w_cof_last;
    logic [9*DATA_W-1:0]       r_mat;
    logic                      r_modo;
    logic signed [MIN_W-1:0]   r_m0, r_m1, r_m2;
    logic signed [MIN_W-1:0]   w_minor_cur, w_minor_nxt;
    logic signed [DATA_W-1:0]  w_el [0:8];
    logic signed [DATA_W-1:0]  w_mul_a;
    logic signed [MIN_W-1:0]   w_mul_b;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [FULL_W-1:0]  w_prod_ext, w_acc_nxt, r_acc;
    logic                      w_ovf;
    logic [DATA_W-1:0]         r_res;
    logic [FULL_W-1:0]         r_res_full;
    logic                      r_ovf;

    // Handshake: a request is taken on any rising edge where start=1 and busy=0
    // (IDLE or FIM); while busy=1 start is ignored, and done pulses for exactly
    // the one cycle in which the new results first appear on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_accept    = 1'b0;
        w_cof_last  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_FIM: begin
                done = (r_state == S_FIM);
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = modo ? S_MINOR : S_COF;
                    w_step_nxt  = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MINOR: begin
                busy = 1'b1;
                if (r_step == 3'd5) begin
                    w_state_nxt = S_COF;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end
            S_COF: begin
                busy       = 1'b1;
                w_cof_last = r_modo ? (r_step == 3'd2) : (r_step == 3'd1);
                if (w_cof_last) begin
                    w_state_nxt = S_FIM;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_el[k] = r_mat[k*DATA_W +: DATA_W];
        end
    end

    // Operand schedule: minors M0..M2 take two steps each, then the cofactor row.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_MINOR: begin
                case (r_step)
                    3'd0:    begin w_mul_a = w_el[4]; w_mul_b = MIN_W'(w_el[8]); end
                    3'd1:    begin w_mul_a = w_el[5]; w_mul_b = MIN_W'(w_el[7]); end
                    3'd2:    begin w_mul_a = w_el[3]; w_mul_b = MIN_W'(w_el[8]); end
                    3'd3:    begin w_mul_a = w_el[5]; w_mul_b = MIN_W'(w_el[6]); end
                    3'd4:    begin w_mul_a = w_el[3]; w_mul_b = MIN_W'(w_el[7]); end
                    default: begin w_mul_a = w_el[4]; w_mul_b = MIN_W'(w_el[6]); end
                endcase
            end
            S_COF: begin
                if (r_modo) begin
                    case (r_step)
                        3'd0:    begin w_mul_a = w_el[0]; w_mul_b = r_m0; end
                        3'd1:    begin w_mul_a = w_el[1]; w_mul_b = r_m1; end
                        default: begin w_mul_a = w_el[2]; w_mul_b = r_m2; end
                    endcase
                end else if (r_step == 3'd0) begin
                    w_mul_a = w_el[0];
                    w_mul_b = MIN_W'(w_el[4]);
                end else begin
                    w_mul_a = w_el[1];
                    w_mul_b = MIN_W'(w_el[3]);
                end
            end
            default: ;
        endcase
    end

    assign w_prod     = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
    assign w_prod_ext = FULL_W'(w_prod);

    always_comb begin
        case (r_step[2:1])
            2'd0:    w_minor_cur = r_m0;
            2'd1:    w_minor_cur = r_m1;
            default: w_minor_cur = r_m2;
        endcase
        w_minor_nxt = r_step[0] ? (w_minor_cur - w_prod[MIN_W-1:0]) : w_prod[MIN_W-1:0];
        case (r_step)
            3'd0:    w_acc_nxt = w_prod_ext;
            3'd1:    w_acc_nxt = r_acc - w_prod_ext;
            default: w_acc_nxt = r_acc + w_prod_ext;
        endcase
        // In range iff every bit from the DATA_W sign bit upward agrees.
        w_ovf = !((&w_acc_nxt[FULL_W-1:DATA_W-1]) || !(|w_acc_nxt[FULL_W-1:DATA_W-1]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mat      <= '0;
            r_modo     <= 1'b0;
            r_m0       <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
            r_acc      <= '0;
            r_res      <= '0;
            r_res_full <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mat  <= matriz;
                r_modo <= modo;
            end
            if (r_state == S_MINOR) begin
                case (r_step[2:1])
                    2'd0:    r_m0 <= w_minor_nxt;
                    2'd1:    r_m1 <= w_minor_nxt;
                    default: r_m2 <= w_minor_nxt;
                endcase
            end
            // Results load on the edge into FIM so they are valid alongside done.
            if (r_state == S_COF) begin
                r_acc <= w_acc_nxt;
                if (w_cof_last) begin
                    r_res_full <= w_acc_nxt;
                    r_res      <= w_acc_nxt[DATA_W-1:0];
                    r_ovf      <= w_ovf;
                end
            end
        end
    end

    assign resultado      = r_res;
    assign resultado_full = r_res_full;
    assign overflow       = r_ovf;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mod_det_seq.sv
// Bench for mod_det_seq: directed cases, handshake/reset corners and random
// matrices checked against a Leibniz-formula determinant model.
module tb_mod_det_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        modo;
    logic [71:0] matriz;
    logic        busy;
    logic        done;
    logic [7:0]  resultado;
    logic [25:0] resultado_full;
    logic        overflow;
    logic [1:0]  o_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [25:0] exp_q[$];

    mod_det_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .modo           (modo),
        .matriz         (matriz),
        .busy           (busy),
        .done           (done),
        .resultado      (resultado),
        .resultado_full (resultado_full),
        .overflow       (overflow),
        .o_dbg_state    (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint det_ref(input logic m, input logic [71:0] mat);
        longint e[9];
        for (int k = 0; k < 9; k++) e[k] = longint'($signed(mat[k*8 +: 8]));
        if (!m) return e[0]*e[4] - e[1]*e[3];
        return e[0]*e[4]*e[8] + e[1]*e[5]*e[6] + e[2]*e[3]*e[7]
             - e[2]*e[4]*e[6] - e[1]*e[3]*e[8] - e[0]*e[5]*e[7];
    endfunction

    function automatic logic [71:0] pack9(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int i);
        return {i[7:0], h[7:0], g[7:0], f[7:0], e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [71:0] rand_mat();
        logic [71:0] r;
        for (int k = 0; k < 9; k++) begin
            case ($urandom_range(0, 3))
                0:       r[k*8 +: 8] = 8'h80;
                1:       r[k*8 +: 8] = 8'h7f;
                default: r[k*8 +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation. b2b=1 means the caller is already at a done-cycle
    // negedge and the start goes out in that same cycle. inj>0 pulses a
    // spurious start at that cycle of the operation.
    task automatic run_op(input string tag, input logic m, input logic [71:0] mat,
                          input int inj, input bit b2b);
        longint      d;
        logic [25:0] e;
        logic [25:0] got;
        int          lat;
        int          nb;
        d = det_ref(m, mat);
        e = d[25:0];
        exp_q.push_back(e);
        if (!b2b) @(negedge clk);
        start  = 1'b1;
        modo   = m;
        matriz = mat;
        @(negedge clk);
        start  = 1'b0;
        modo   = 1'($urandom_range(0, 1));
        matriz = {$urandom, $urandom, $urandom};
        lat = 1;
        nb  = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (busy === 1'b1) nb++;
            if (lat == inj) begin
                start  = 1'b1;
                modo   = ~m;
                matriz = rand_mat();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), m ? 64'd10 : 64'd3);
        check({tag, "_busy_cycles"}, 64'(nb), 64'(lat - 1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        got = exp_q.pop_front();
        check({tag, "_full"}, 64'(resultado_full), 64'(got));
        check({tag, "_res"}, 64'(resultado), 64'(got[7:0]));
        check({tag, "_ovf"}, 64'(overflow), 64'((d < -128) || (d > 127)));
    endtask

    initial begin
        int          dmask;
        int          nd;
        logic [71:0] mp;
        reset  = 1'b1;
        start  = 1'b0;
        modo   = 1'b0;
        matriz = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(resultado), 64'd0);
        check("rst_full", 64'(resultado_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Directed cases; unused 3x3 elements carry junk for the 2x2 runs.
        run_op("t1_2x2", 1'b0, pack9(3, 2, 77, 1, 4, -9, 55, -1, 12), 0, 0);
        run_op("t2_2x2_ovf", 1'b0, pack9(100, 0, 5, 0, 100, 6, 7, 8, 9), 0, 0);
        run_op("t3_3x3", 1'b1, pack9(1, 2, 3, 0, 1, 4, 5, 6, 0), 0, 0);
        run_op("t4_3x3_neg", 1'b1, pack9(6, 1, 1, 4, -2, 5, 2, 8, 7), 0, 0);
        run_op("t4_all_min", 1'b1, pack9(-128, -128, -128, -128, -128, -128, -128, -128, -128), 0, 0);
        run_op("t4_2x2_min", 1'b0, pack9(-128, 127, 0, -128, -128, 0, 0, 0, 0), 0, 0);

        // Busy start ignored, then start in the done cycle accepted.
        run_op("t5_ignore", 1'b1, pack9(2, -3, 4, 7, 1, -5, 3, 9, -6), 4, 0);
        run_op("t5_b2b", 1'b0, pack9(5, 3, 0, 2, 7, 0, 0, 0, 0), 0, 1);
        @(negedge clk);
        check("t5_done_one_cycle", 64'(done), 64'd0);

        // Held start re-triggers at every acceptance point.
        mp = pack9(9, 4, 0, -2, 3, 0, 0, 0, 0);
        start  = 1'b1;
        modo   = 1'b0;
        matriz = mp;
        dmask  = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) dmask |= (1 << k);
        end
        start = 1'b0;
        check("held_done_cycles", 64'(dmask), 64'((1 << 3) | (1 << 6)));
        check("held_full", 64'(resultado_full), 64'd35);
        @(negedge clk);
        check("held_idle_after", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation aborts with no done pulse.
        @(negedge clk);
        start  = 1'b1;
        modo   = 1'b1;
        matriz = pack9(3, 1, 2, 4, 5, 6, 7, 8, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_res", 64'(resultado), 64'd0);
        check("abort_full", 64'(resultado_full), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op("t6_after_rst", 1'b1, pack9(3, 1, 2, 4, 5, 6, 7, 8, 1), 0, 0);

        // Random matrices, random modes and spacing.
        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rand_mat(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                   1'($urandom_range(0, 1)));
        end
        repeat (2) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
